// File: rtl/pb_irq_ctrl.sv
// Push-button event and interrupt controller.
// Generates the debouncer's sample strobe, turns debounced button levels into
// latched press/release events, and drives one interrupt request with an
// acknowledge / end-of-interrupt handshake. Register map: PEND at BASE,
// MASK at BASE+1, CTRL at BASE+2. Read data is zero elsewhere so it can be
// OR-combined with the other peripherals on the bus.
module pb_irq_ctrl #(
  parameter logic [23:0] TICK_DIV = 24'd1000000,
  parameter logic [7:0]  BASE     = 8'hF9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  input  logic [4:0] state,
  output logic       tick,
  output logic       irq,
  input  logic       irq_ack
);

  localparam logic [7:0]  ADDR_PEND = BASE;
  localparam logic [7:0]  ADDR_MASK = BASE + 8'd1;
  localparam logic [7:0]  ADDR_CTRL = BASE + 8'd2;
  localparam logic [23:0] CNT_LAST  = TICK_DIV - 24'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_fsm_t;

  // Register file
  logic [4:0] pend_q;
  logic [4:0] mask_q;
  logic       ie_q;
  logic       tick_en_q;
  logic       pol_q;

  // Edge detection
  logic [4:0] prev_q;
  logic       armed_q;
  logic [4:0] ev;
  logic [4:0] ev_q;

  // Tick counter and interrupt sequencer
  logic [23:0] cnt_q;
  irq_fsm_t    fsm_q;

  logic       wr_pend;
  logic       wr_mask;
  logic       wr_ctrl;
  logic [4:0] clr;
  logic       hit;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^wdata[7:5];

  assign wr_pend = we && (addr == ADDR_PEND);
  assign wr_mask = we && (addr == ADDR_MASK);
  assign wr_ctrl = we && (addr == ADDR_CTRL);

  assign clr = wr_pend ? wdata[4:0] : 5'd0;
  assign hit = |(pend_q & mask_q);

  // Raw edge vector; nothing is reported until prev_q holds a real sample.
  assign ev = armed_q ? (pol_q ? (prev_q & ~state) : (state & ~prev_q)) : 5'd0;

  assign tick = tick_en_q && (cnt_q == CNT_LAST);

  // Bus read mux: combinational from addr, zero for addresses we do not own.
  always_comb begin
    // NOTE: default assignment first so every path drives rdata and no latch is inferred.
    rdata = 8'h00;
    case (addr)
      ADDR_PEND: rdata = {3'b000, pend_q};
      ADDR_MASK: rdata = {3'b000, mask_q};
      ADDR_CTRL: rdata = {5'b00000, pol_q, tick_en_q, ie_q};
      default:   rdata = 8'h00;
    endcase
  end

  // Track previous level, arm after the first cycle, and register the event
  // vector so PEND updates one edge after prev_q has lagged state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      prev_q  <= 5'd0;
      armed_q <= 1'b0;
      ev_q    <= 5'd0;
    end else begin
      prev_q  <= state;
      armed_q <= 1'b1;
      ev_q    <= ev;
    end
  end

  // PEND / MASK / CTRL registers; a new event beats a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 5'd0;
      mask_q    <= 5'd0;
      ie_q      <= 1'b0;
      tick_en_q <= 1'b1;
      pol_q     <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~clr) | ev_q;
      if (wr_mask) begin
        mask_q <= wdata[4:0];
      end
      if (wr_ctrl) begin
        ie_q      <= wdata[0];
        tick_en_q <= wdata[1];
        pol_q     <= wdata[2];
      end
    end
  end

  // Sample-strobe counter; held at zero while disabled so re-enabling
  // always restarts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 24'd0;
    end else if (!tick_en_q || (cnt_q == CNT_LAST)) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  // Interrupt sequencer: IDLE -> REQ on an enabled pending event, REQ ->
  // SERVICE on acknowledge, SERVICE -> IDLE on any PEND write (EOI).
  // irq is registered and high exactly while in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      irq   <= 1'b0;
    end else if (!ie_q) begin
      fsm_q <= IDLE;
      irq   <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (hit) begin
            fsm_q <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            fsm_q <= SERVICE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_pend) begin
            fsm_q <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule
